// File: rtl/cdc_fifo_rptr_status_if.sv
// Read-side bus of the async CDC FIFO read-pointer/status block.
// Carries r_underflow only when CDC_FIFO_RPTR_UNDERFLOW_EN is defined.
interface cdc_fifo_rptr_status_if #(
    parameter int unsigned ADDR_SIZE = 4
);
    localparam int unsigned PW = ADDR_SIZE + 1;

    logic                 r_inc;
    logic [PW-1:0]        r_q2_wptr;
    logic [PW-1:0]        r_aempty_thresh;
    logic                 r_empty;
    logic                 r_almost_empty;
    logic [PW-1:0]        r_count;
    logic [PW-1:0]        r_ptr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [ADDR_SIZE-1:0] r_addr_next;
`ifdef CDC_FIFO_RPTR_UNDERFLOW_EN
    logic                 r_underflow;

    modport master (
        output r_inc, r_q2_wptr, r_aempty_thresh,
        input  r_empty, r_almost_empty, r_count, r_ptr, r_addr, r_addr_next, r_underflow
    );
    modport slave (
        input  r_inc, r_q2_wptr, r_aempty_thresh,
        output r_empty, r_almost_empty, r_count, r_ptr, r_addr, r_addr_next, r_underflow
    );
`else
    modport master (
        output r_inc, r_q2_wptr, r_aempty_thresh,
        input  r_empty, r_almost_empty, r_count, r_ptr, r_addr, r_addr_next
    );
    modport slave (
        input  r_inc, r_q2_wptr, r_aempty_thresh,
        output r_empty, r_almost_empty, r_count, r_ptr, r_addr, r_addr_next
    );
`endif
endinterface

// File: rtl/cdc_fifo_rptr_status.sv
// Read-domain pointer, empty/almost-empty and occupancy generator for the async CDC FIFO.
// Optional sticky underflow flag: define CDC_FIFO_RPTR_UNDERFLOW_EN.
module cdc_fifo_rptr_status #(
    parameter int unsigned ADDR_SIZE  = 4,
    parameter bit          AEMPTY_RST = 1'b1
) (
    input  logic                    r_clk,
    input  logic                    r_rst_n,
    cdc_fifo_rptr_status_if.slave   bus
);
    localparam int unsigned PW = ADDR_SIZE + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_bin_next;
    logic [PW-1:0] r_gray_next;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] cnt_next;
    logic          r_rd;

    // Next pointer, decoded write pointer and next occupancy
    always_comb begin
        r_rd        = bus.r_inc & ~bus.r_empty;
        r_bin_next  = r_bin + PW'(r_rd);
        r_gray_next = (r_bin_next >> 1) ^ r_bin_next;
        w_bin       = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_bin[i] = ^(bus.r_q2_wptr >> i);
        end
        cnt_next = w_bin - r_bin_next;
    end

    // Empty uses the Gray compare so the decode stays off that path
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_bin              <= '0;
            bus.r_ptr          <= '0;
            bus.r_empty        <= 1'b1;
            bus.r_count        <= '0;
            bus.r_almost_empty <= AEMPTY_RST;
        end else begin
            r_bin              <= r_bin_next;
            bus.r_ptr          <= r_gray_next;
            bus.r_empty        <= (r_gray_next == bus.r_q2_wptr);
            bus.r_count        <= cnt_next;
            bus.r_almost_empty <= (cnt_next <= bus.r_aempty_thresh);
        end
    end

    assign bus.r_addr      = r_bin[ADDR_SIZE-1:0];
    assign bus.r_addr_next = r_bin_next[ADDR_SIZE-1:0];

`ifdef CDC_FIFO_RPTR_UNDERFLOW_EN
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            bus.r_underflow <= 1'b0;
        end else if (bus.r_inc && bus.r_empty) begin
            bus.r_underflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    underflow_report: assert property (@(posedge r_clk) disable iff (!r_rst_n)
        !(bus.r_inc && bus.r_empty))
        else $warning("cdc_fifo_rptr_status: read request while empty ignored");
`endif
`endif

endmodule

// File: doc/cdc_fifo_rptr_status.md
Name: cdc_fifo_rptr_status

Overview:
Read-domain pointer and status generator for the async (Cummings-style) CDC FIFO, successor to the basic read-pointer/empty block. Keeps binary and Gray read pointers and a registered empty flag. Adds an occupancy count from the synchronised write pointer, a programmable almost-empty flag, and a look-ahead read address for registered-output iCE40 BRAM. Sits in the read clock domain between the 2-flop wptr synchroniser and the FIFO memory.

Parameters:
ADDR_SIZE, 4, memory address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits
AEMPTY_RST, 1, reset value of r_almost_empty (1 = asserted)

Ports:
r_clk  input  1  read-domain clock; all state on rising edge
r_rst_n  input  1  asynchronous active-low reset
r_inc  input  1  read request; honoured only when r_empty==0
r_q2_wptr  input  ADDR_SIZE+1  write pointer, Gray coded, already synchronised into r_clk
r_aempty_thresh  input  ADDR_SIZE+1  almost-empty threshold in words, sampled every cycle
r_empty  output  1  registered empty flag
r_almost_empty  output  1  registered; occupancy <= r_aempty_thresh
r_count  output  ADDR_SIZE+1  registered occupancy in words, 0..2**ADDR_SIZE
r_ptr  output  ADDR_SIZE+1  registered Gray read pointer, to write-domain synchroniser
r_addr  output  ADDR_SIZE  current read address = r_bin[ADDR_SIZE-1:0]
r_addr_next  output  ADDR_SIZE  r_bin_next[ADDR_SIZE-1:0], combinational, for BRAM read-address port

Behaviour:
- Reset: asynchronous assert, synchronous release via r_clk; all registers use asynchronous reset.
- Reset values: r_bin=0, r_ptr=0, r_empty=1, r_count=0, r_almost_empty=AEMPTY_RST.
- Reset mid-operation clears all state immediately, with no dependence on r_clk. First accept is possible 1 cycle after release, once r_empty is recomputed.
- Effective read: r_rd = r_inc & ~r_empty. r_inc while r_empty==1 is ignored, and the pointer holds.
- r_bin_next = r_bin + r_rd, mod 2**(ADDR_SIZE+1). r_gray_next = (r_bin_next>>1) ^ r_bin_next. Both registered each cycle.
- Write-pointer decode: w_bin = Gray-to-binary of r_q2_wptr. Combinational XOR prefix, MSB down.
- Occupancy: cnt_next = w_bin - r_bin_next, modulo 2**(ADDR_SIZE+1). Always in 0..depth because the pointers differ by at most depth. Registered into r_count.
- Empty: r_empty <= (r_gray_next == r_q2_wptr). This equals cnt_next==0; the Gray compare is used so there is no decode on the critical path.
- Almost empty: r_almost_empty <= (cnt_next <= r_aempty_thresh), unsigned compare.
  - Threshold 0 makes it track r_empty.
  - Threshold >= depth keeps it always 1.
- Latency: a change on r_q2_wptr is reflected in r_empty, r_count and r_almost_empty 1 r_clk later. An accepted read is reflected 1 cycle later.
- Simultaneous read and wptr advance in the same cycle: both are reflected together. Net count = old + write delta - 1.
- Wrap-around: the pointer MSB toggles every depth reads. r_addr wraps depth-1 -> 0. Count and empty stay correct across the wrap.
- Pessimism: wptr arrives late through the synchroniser, so status is conservative. r_empty may read 1 while data exists; it never reads 0 on an empty FIFO.
- No state machine beyond the pointer and flag registers.

Optional Feature:
Macro CDC_FIFO_RPTR_UNDERFLOW_EN.
- Defined: adds output r_underflow (1 bit, sticky).
  - Set on any cycle with r_inc==1 and r_empty==1.
  - Cleared only by reset; reset value 0.
  - Also adds a simulation-only assertion that reports the event.
- Undefined: port absent and no extra logic; underflowing reads are silently ignored as above.

Test Plan:
- Reset, ADDR_SIZE=4: hold r_rst_n=0 and toggle inputs -> r_empty=1, r_count=0, r_ptr=0, r_addr=0, r_almost_empty=1. Then check the async assert mid-cycle: outputs clear before the next r_clk edge.
- Step r_q2_wptr Gray 0->1->3->2 (bin 3), no reads -> r_empty=0 one cycle after the first step, r_count=3. Then assert r_inc 3 cycles -> r_addr 0,1,2, r_count 2,1,0, r_empty=1 after the 3rd read.
- r_aempty_thresh=2, wptr bin=5: read one word per cycle -> r_almost_empty goes 0->1 on the cycle r_count becomes 2. Thresh=0 -> r_almost_empty mirrors r_empty.
- Wrap: 40 writes/reads interleaved (>2*depth) with a concurrent wptr increment and read -> r_count held constant. r_ptr equals the Gray of the read count mod 32. r_addr wraps 15->0.
- Full: wptr bin=16 with r_bin=0 -> r_count=16, r_almost_empty=0 for thresh=15. A read gives r_count=15, then r_almost_empty=1.
- Underflow, macro defined: r_inc=1 while r_empty -> r_bin unchanged, r_underflow=1 and stays set through later valid reads until reset. Macro undefined: same pointer behaviour, no port.
